// File: rtl/fsm_pulsos_pkg.sv
// Shared types and constants for the push-button edge-to-pulse converter.
package fsm_pulsos_pkg;

    // Controller states; 2'b11 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        PULSE    = 2'b01,
        WAIT_REL = 2'b10
    } state_e;

    // Default pulse length in clock cycles.
    localparam int PULSE_WIDTH_DEF = 1;

    // Width of the pulse-length counter: enough bits to hold PULSE_WIDTH,
    // never less than one bit.
    function automatic int cnt_width(input int pw);
        int w;
        w = $clog2(pw + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/fsm_pulsos.sv
// Push-button edge-to-pulse converter. Every press of an already
// synchronised, debounced button produces exactly one pulse of
// PULSE_WIDTH cycles on pulse_o, however long the button is held.
// pulse_o comes straight from a flop, so there is no combinational
// path from button_i to the output.
module fsm_pulsos
    import fsm_pulsos_pkg::*;
#(
    parameter int PULSE_WIDTH = PULSE_WIDTH_DEF
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic button_i,
    output logic pulse_o
);

    localparam int               CNT_W   = cnt_width(PULSE_WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PULSE_WIDTH);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             pulse_q;
    logic             pulse_d;
    logic             cnt_done;

    // The pulse has run its full length once the counter reaches the width.
    assign cnt_done = (cnt_q >= CNT_MAX);

    // State register; reset forces IDLE at once, truncating any pulse.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; button changes during PULSE are ignored until the
    // pulse completes, and a new press is only seen from IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (button_i) begin
                    state_d = PULSE;
                end
            end
            PULSE: begin
                if (cnt_done) begin
                    state_d = button_i ? WAIT_REL : IDLE;
                end
            end
            WAIT_REL: begin
                if (!button_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Counter next value: loads 1 on the press edge, counts through PULSE,
    // and is held at zero everywhere else.
    always_comb begin
        cnt_d = cnt_q;
        case (state_q)
            IDLE:    cnt_d = button_i ? CNT_ONE : '0;
            PULSE:   cnt_d = cnt_done ? '0 : cnt_q + CNT_ONE;
            default: cnt_d = '0;
        endcase
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Moore output decode from the next state, so the registered output
    // rises on the same edge that enters PULSE.
    always_comb begin
        pulse_d = (state_d == PULSE);
    end

    // Output register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: tb/tb_fsm_pulsos.sv
// Directed bench for fsm_pulsos with two instances: PULSE_WIDTH=1 and 4.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_fsm_pulsos;
    import fsm_pulsos_pkg::*;

    logic clk = 1'b0;
    logic rst1_n;
    logic btn1;
    logic p1;
    logic rst4_n;
    logic btn4;
    logic p4;

    int n_checks = 0;
    int n_errors = 0;

    // Clock: 10 time-unit period.
    always #5 clk = ~clk;

    fsm_pulsos #(.PULSE_WIDTH(1)) dut1 (
        .clk_i    (clk),
        .rst_n_i  (rst1_n),
        .button_i (btn1),
        .pulse_o  (p1)
    );

    fsm_pulsos #(.PULSE_WIDTH(4)) dut4 (
        .clk_i    (clk),
        .rst_n_i  (rst4_n),
        .button_i (btn4),
        .pulse_o  (p4)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Apply n button levels (bvec, MSB first = earliest) one per cycle to the
    // chosen instance and compare pulse_o after each edge against evec.
    task automatic drive_vec(input string tag, input bit use4, input int n,
                             input logic [15:0] bvec, input logic [15:0] evec);
        for (int i = 0; i < n; i++) begin
            if (use4) btn4 = bvec[n-1-i];
            else      btn1 = bvec[n-1-i];
            @(negedge clk);
            check_eq($sformatf("%s[%0d]", tag, i),
                     32'(use4 ? p4 : p1), 32'(evec[n-1-i]));
        end
    endtask

    initial begin
        logic   tog_b [4];
        logic   tog_p [4];
        state_e tog_s [4];
        int     h;
        int     l;
        int     cnt;
        int     total;

        tog_b = '{1'b1, 1'b0, 1'b1, 1'b0};
        tog_p = '{1'b1, 1'b0, 1'b1, 1'b0};
        tog_s = '{PULSE, IDLE, PULSE, IDLE};

        // Reset held for two cycles with the button low.
        rst1_n = 1'b0;
        rst4_n = 1'b0;
        btn1   = 1'b0;
        btn4   = 1'b0;
        #1;
        check_eq("rst_p1_t0", 32'(p1), 32'd0);
        check_eq("rst_p4_t0", 32'(p4), 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_eq($sformatf("rst_p1_c%0d", i), 32'(p1), 32'd0);
            check_eq($sformatf("rst_p4_c%0d", i), 32'(p4), 32'd0);
        end
        rst1_n = 1'b1;
        rst4_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_state1", 32'(dut1.state_q), 32'(IDLE));
        check_eq("post_rst_state4", 32'(dut4.state_q), 32'(IDLE));
        check_eq("post_rst_p1", 32'(p1), 32'd0);

        // Width 1, button held 7 cycles: one pulse cycle, then WAIT_REL.
        drive_vec("hold7a", 1'b0, 3, 16'(3'b111), 16'(3'b100));
        check_eq("hold7_wait_rel", 32'(dut1.state_q), 32'(WAIT_REL));
        drive_vec("hold7b", 1'b0, 6, 16'(6'b111100), 16'(6'b000000));
        check_eq("hold7_idle", 32'(dut1.state_q), 32'(IDLE));

        // Width 1, toggling every cycle: one pulse per high cycle.
        for (int i = 0; i < 4; i++) begin
            btn1 = tog_b[i];
            @(negedge clk);
            check_eq($sformatf("toggle_p[%0d]", i), 32'(p1), 32'(tog_p[i]));
            check_eq($sformatf("toggle_s[%0d]", i), 32'(dut1.state_q), 32'(tog_s[i]));
        end

        // Width 1, 20 presses of random high/low lengths: one pulse each.
        total = 0;
        for (int p = 0; p < 20; p++) begin
            h   = int'($urandom_range(1, 10));
            l   = int'($urandom_range(1, 10));
            cnt = 0;
            for (int j = 0; j < h; j++) begin
                btn1 = 1'b1;
                @(negedge clk);
                cnt += int'(p1);
            end
            for (int j = 0; j < l; j++) begin
                btn1 = 1'b0;
                @(negedge clk);
                cnt += int'(p1);
            end
            check_eq($sformatf("rand_press%0d", p), 32'(cnt), 32'd1);
            total += cnt;
        end
        check_eq("rand_total", 32'(total), 32'd20);

        // Width 4, one-cycle press plus a second press inside the pulse.
        drive_vec("pw4_short", 1'b1, 8, 16'(8'b10010000), 16'(8'b11110000));
        check_eq("pw4_short_idle", 32'(dut4.state_q), 32'(IDLE));

        // Width 4, button held past the pulse end.
        drive_vec("pw4_hold", 1'b1, 7, 16'(7'b1111100), 16'(7'b1111000));

        // Width 4, reset asserted two cycles into a pulse.
        btn4 = 1'b1;
        @(negedge clk);
        check_eq("rstmid_c1", 32'(p4), 32'd1);
        @(negedge clk);
        check_eq("rstmid_c2", 32'(p4), 32'd1);
        #2;
        rst4_n = 1'b0;
        #1;
        check_eq("rstmid_async_p", 32'(p4), 32'd0);
        check_eq("rstmid_async_s", 32'(dut4.state_q), 32'(IDLE));
        check_eq("rstmid_async_cnt", 32'(dut4.cnt_q), 32'd0);
        @(negedge clk);
        check_eq("rstmid_held", 32'(p4), 32'd0);
        rst4_n = 1'b1;
        drive_vec("after_rst", 1'b1, 5, 16'(5'b10000), 16'(5'b11110));
        check_eq("after_rst_idle", 32'(dut4.state_q), 32'(IDLE));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fsm_pulsos.md
Name: fsm_pulsos

Overview:
- Push-button edge-to-pulse converter.
- Each press (low-to-high level of button_i, sampled on clk_i) yields exactly one pulse of PULSE_WIDTH clock cycles on pulse_o, however long the button is held.
- Sits after an external debouncer/synchronizer; button_i is assumed already synchronous to clk_i.
- Implemented as a small Moore FSM with a registered output.

Parameters:
- PULSE_WIDTH, 1: pulse length in clk_i cycles; legal range 1..255.

Ports:
- clk_i  input  1  system clock; all state changes on its rising edge.
- rst_n_i  input  1  reset; one clock, reset is asynchronous and active-low.
- button_i  input  1  button level, synchronous to clk_i, active-high.
- pulse_o  input/output: output  1  single pulse per press, active-high, registered.

Behaviour:
- States: IDLE, PULSE, WAIT_REL.
- Width counter: $clog2(PULSE_WIDTH+1) bits, minimum 1 bit.
- Reset (rst_n_i=0, asynchronous): state=IDLE, counter=0, pulse_o=0 immediately.
  - Reset asserted mid-pulse truncates the pulse at once.
- IDLE:
  - button_i=1 at edge k -> PULSE at edge k; pulse_o=1 from edge k.
  - Latency is one edge: pulse_o is high in the cycle following the sampling edge.
  - Counter loads 1.
- PULSE:
  - pulse_o=1.
  - Counter < PULSE_WIDTH -> stay in PULSE and increment.
  - Counter = PULSE_WIDTH -> leave PULSE: to WAIT_REL if button_i=1, to IDLE if button_i=0.
  - button_i changes while in PULSE are ignored; the pulse always runs full width.
  - With PULSE_WIDTH=1, pulse_o is high for exactly one cycle.
- WAIT_REL:
  - pulse_o=0.
  - Stay while button_i=1; go to IDLE on the first edge sampling button_i=0.
- pulse_o is a pure function of registered state (no combinational path from button_i).
- Button high when reset releases: counts as a new press; a pulse is issued at the first edge after release.
- One-cycle press (1,0): one full pulse, then IDLE.
- Back-to-back presses (1,0,1,0 toggling every cycle, PULSE_WIDTH=1): one pulse per high cycle.
  - State sequence: IDLE->PULSE->IDLE->PULSE.
- Press whose release falls inside a longer pulse (PULSE_WIDTH>1): no extra pulse.
  - A new press is recognised only after returning to IDLE.
- Unreachable state encodings: recover to IDLE with pulse_o=0.

Decomposition:
- Package fsm_pulsos_pkg:
  - state enum (IDLE, PULSE, WAIT_REL; 2-bit logic encoding);
  - localparam for default PULSE_WIDTH.
- Single module; no sub-module. State register, counter and next-state logic live in separate always blocks.

Test Plan:
- Reset held 2 cycles with button_i=0 -> pulse_o=0 throughout; state IDLE after release.
- Button held high 7 cycles (PULSE_WIDTH=1) -> pulse_o=1 for exactly 1 cycle, starting one edge after the first sampled high; 0 for the remaining hold.
- 20 presses with random high/low lengths of 1..10 cycles -> exactly 1 pulse cycle counted per press, 20 pulses total.
- Button toggling every cycle (1,0,1,0) -> pulse_o sequence 1,0,1,0 delayed one edge; 2 pulses.
- PULSE_WIDTH=4, one-cycle press -> pulse_o high exactly 4 consecutive cycles; a second press arriving during the pulse produces no extra pulse.
- rst_n_i asserted during a pulse (PULSE_WIDTH=4, after 2 cycles) -> pulse_o=0 immediately, without waiting for a clock edge; button still high at release -> new pulse one edge later.
